add_43bits_arb: RTL and testbench
=================================

# add_43bits_arb

Round-robin arbiter and sequencer that shares one `add_43bits` instance among `N_REQ` requesters inside the floating-point multiplier. It supports single-beat 43-bit additions and multi-beat chained additions, where one requester holds the adder for several beats and the carry ripples from beat to beat. The result goes into a one-entry registered output slot with valid/ready back-pressure.

## Interface
- `N_REQ`, 2, number of requesters (2..4).
- `ID_W`, 2, width of the requester index, at least clog2(`N_REQ`).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  `N_REQ`  per-requester request valid.
- `o_req_ready`  out  `N_REQ`  per-requester accept; a beat transfers on valid & ready.
- `i_req_last`  in  `N_REQ`  marks the final beat of a request; 1 on a first beat means single-beat.
- `i_data_one`  in  `N_REQ`*43  operand A; requester k occupies bits [43k+42:43k].
- `i_data_two`  in  `N_REQ`*43  operand B; same packing as `i_data_one`.
- `i_carry`  in  `N_REQ`  carry-in, used on the first beat only.
- `o_rsp_valid`  out  1  output slot holds a result.
- `i_rsp_ready`  in  1  consumer accepts the result.
- `o_rsp_id`  out  `ID_W`  index of the requester that owns the result.
- `o_rsp_last`  out  1  copy of `i_req_last` for the beat.
- `o_data`  out  43  sum.
- `o_carry`  out  1  carry-out.

## Operation
- FSM states:
  - ARB: free arbitration.
  - LOCK: adder owned by `owner` until its last beat.
- Grant in ARB:
  - Round-robin from pointer `rr_ptr`: the first k with `i_req_valid[k]`, searching `rr_ptr`, `rr_ptr`+1, … mod `N_REQ`.
  - On acceptance, `rr_ptr` becomes granted index + 1 (mod `N_REQ`).
- `slot_free` = !`o_rsp_valid` | `i_rsp_ready`.
- `o_req_ready[k]` = `slot_free` & (k is the current grant); it is one-hot or zero. No requester is ready while the slot is blocked.
- Accepted beat in ARB:
  - The adder carry-in is `i_carry[k]`.
  - If `i_req_last[k]`=0: go to LOCK, `owner`=k, `chain_c` = adder carry-out.
  - Otherwise stay in ARB.
- Accepted beat in LOCK:
  - Only `owner` can be granted; the adder carry-in is `chain_c`, and `i_carry[owner]` is ignored.
  - `chain_c` is updated with each carry-out.
  - When `i_req_last` is accepted, return to ARB and advance `rr_ptr` past `owner`.
- Owner drops valid mid-burst: stay in LOCK and stall all other requesters indefinitely. There is no timeout.
- Output slot:
  - On acceptance, the slot loads `o_data`, `o_carry`, `o_rsp_id`, `o_rsp_last` and sets `o_rsp_valid`.
  - When the slot drains (valid & `i_rsp_ready`) with no new acceptance, `o_rsp_valid` clears and the data fields hold their last value.
  - While valid & !ready, all output fields stay stable.
- Arithmetic: {`o_carry`,`o_data`} = A + B + cin, modulo 2^44. There is no saturation.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Outputs: `o_rsp_valid`=0, `o_data`=0, `o_carry`=0, `o_rsp_id`=0, `o_rsp_last`=0.
  - Internal state: ARB, `rr_ptr`=0, `chain_c`=0.
  - `o_req_ready`=0 while `i_rst_n`=0.
- Latency: a beat accepted at edge t is visible on the outputs after edge t.
- Throughput: 1 beat per cycle when `i_rsp_ready` is held high. Draining and accepting in the same cycle is permitted and back-to-back.
- Reset mid-burst drops the lock and the partial chain. Requesters must restart the burst.
- `o_req_ready` is combinational from `i_req_valid`, `i_rsp_ready`, state and `rr_ptr`. Requesters must not make `i_req_valid` depend on `o_req_ready`.

## Structure
- Shared package `fp_mul_pkg`:
  - `WORD_W`=43.
  - typedef `arb_state_e` {ARB, LOCK}.
  - typedef `rsp_t` {data, carry, id, last}.
- One sub-module: existing `add_43bits`, instantiated once, with operands muxed by grant and carry-in muxed between `i_carry[k]` and `chain_c`.
- Round-robin pick is a function in the package. No further sub-modules.

## Test plan
- Single beat, N_REQ=2: req0 A=43'h1, B=43'h7FF_FFFF_FFFF, cin=0, last=1 → next cycle `o_data`=43'h0, `o_carry`=1, `o_rsp_id`=0.
- Contention: req0 and req1 valid every cycle, last=1, rsp_ready=1 → grants alternate 0,1,0,1 and `o_rsp_id` alternates from cycle 1.
- Chained 86-bit add from req1:
  - Beat 0: A=all-ones, B=1, cin=0, last=0 → `o_data`=0, `o_carry`=1.
  - Beat 1: A=0, B=0, last=1 → `o_data`=1 (carry propagated).
  - req0 is held ready=0 throughout.
- Back-pressure: rsp_ready=0 for 3 cycles with result 43'h123 pending → `o_rsp_valid`=1 and `o_data`=43'h123 stable, all `o_req_ready`=0; on ready=1 the next beat issues in the same cycle.
- Owner stall: req1 in LOCK drops valid for 4 cycles while req0 is valid → no grant to req0 until req1's last beat, then req0 is granted next.
- Reset mid-burst: assert `i_rst_n`=0 after the first beat → all outputs 0 immediately; after release a single-beat req0 is granted and uses `i_carry`, not the stale chain carry.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// ---------------------------------------------------------------------------
// fp_mul_pkg
//   Shared types, constants and helpers for the floating-point multiplier
//   datapath blocks. The adder arbiter uses:
//     WORD_W       - width of one adder operand / result word
//     MAX_REQ      - largest supported requester count
//     IDX_W        - internal requester index width (covers MAX_REQ)
//     arb_state_e  - arbiter FSM states
//     rsp_t        - contents of the registered result slot
//     pick_t       - result of a round-robin search
//     rr_pick()    - round-robin search starting at a pointer
//     rr_next()    - pointer increment modulo the requester count
// ---------------------------------------------------------------------------
package fp_mul_pkg;

    localparam int WORD_W  = 43;
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ARB  = 1'b0,   // free arbitration
        LOCK = 1'b1    // adder owned by one requester until its last beat
    } arb_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              carry;
        logic [IDX_W-1:0]  id;
        logic              last;
    } rsp_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First valid requester found searching ptr, ptr+1, ... modulo n_req.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        n_req
    );
        pick_t       pick;
        int unsigned k;
        pick = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            k = (32'(ptr) + i) % n_req;
            if (i < n_req && !pick.found && valid[k[IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = k[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

    // idx + 1 wrapped to the requester count.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [IDX_W-1:0] idx,
        input int unsigned      n_req
    );
        if (32'(idx) + 1 >= n_req) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/add_43bits.sv
// ---------------------------------------------------------------------------
// add_43bits
//   Purely combinational 43-bit adder with carry-in and carry-out.
//   {o_carry, o_data} = i_data_one + i_data_two + i_carry (mod 2^44).
// Ports:
//   i_data_one  in  43  operand A
//   i_data_two  in  43  operand B
//   i_carry     in  1   carry-in
//   o_data      out 43  sum
//   o_carry     out 1   carry-out
// ---------------------------------------------------------------------------
module add_43bits
    import fp_mul_pkg::*;
(
    input  logic [WORD_W-1:0] i_data_one,
    input  logic [WORD_W-1:0] i_data_two,
    input  logic              i_carry,
    output logic [WORD_W-1:0] o_data,
    output logic              o_carry
);

    logic [WORD_W:0] sum;

    assign sum     = {1'b0, i_data_one} + {1'b0, i_data_two} + {{WORD_W{1'b0}}, i_carry};
    assign o_data  = sum[WORD_W-1:0];
    assign o_carry = sum[WORD_W];

endmodule

// File: rtl/add_43bits_arb.sv
// ---------------------------------------------------------------------------
// add_43bits_arb
//   Round-robin arbiter sharing one add_43bits among N_REQ requesters.
//   Single-beat requests arbitrate freely; a multi-beat request locks the
//   adder to its owner and ripples the carry from beat to beat. Results land
//   in a one-entry registered slot with valid/ready back-pressure.
// Ports:
//   i_clk        in  1           clock
//   i_rst_n      in  1           async active-low reset
//   i_req_valid  in  N_REQ       per-requester beat valid
//   o_req_ready  out N_REQ       per-requester accept (one-hot or zero)
//   i_req_last   in  N_REQ       final beat of a request
//   i_data_one   in  N_REQ*43    operand A, requester k at [43k+42:43k]
//   i_data_two   in  N_REQ*43    operand B, same packing
//   i_carry      in  N_REQ       carry-in, used on a first beat only
//   o_rsp_valid  out 1           result slot occupied
//   i_rsp_ready  in  1           consumer accepts the result
//   o_rsp_id     out ID_W        requester owning the result
//   o_rsp_last   out 1           last flag of the result beat
//   o_data       out 43          sum
//   o_carry      out 1           carry-out
// ---------------------------------------------------------------------------
module add_43bits_arb
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ-1:0]        i_req_last,
    input  logic [N_REQ*WORD_W-1:0] i_data_one,
    input  logic [N_REQ*WORD_W-1:0] i_data_two,
    input  logic [N_REQ-1:0]        i_carry,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic                    o_rsp_last,
    output logic [WORD_W-1:0]       o_data,
    output logic                    o_carry
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] owner_q;
    logic             chain_c_q;
    logic             rsp_valid_q;
    rsp_t             slot_q;

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] last_ext;
    logic [MAX_REQ-1:0] carry_ext;

    pick_t              grant;
    logic               slot_free;
    logic               accept;
    logic               sel_last;
    logic               add_cin;
    logic [WORD_W-1:0]  add_a;
    logic [WORD_W-1:0]  add_b;
    logic [WORD_W-1:0]  add_sum;
    logic               add_cout;

    assign valid_ext = MAX_REQ'(i_req_valid);
    assign last_ext  = MAX_REQ'(i_req_last);
    assign carry_ext = MAX_REQ'(i_carry);

    assign slot_free = !rsp_valid_q || i_rsp_ready;
    // Gating with i_rst_n keeps every requester stalled while reset is held.
    assign accept    = i_rst_n && slot_free && grant.found;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            ARB:     if (accept && !sel_last) state_d = LOCK;
            LOCK:    if (accept &&  sel_last) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // ---------------- FSM: outputs (grant, ready, adder muxes) ----------------
    always_comb begin
        grant       = '0;
        o_req_ready = '0;
        add_a       = '0;
        add_b       = '0;

        if (state_q == ARB) begin
            grant = rr_pick(valid_ext, rr_ptr_q, N_REQ);
        end else begin
            // Only the owner may proceed; everyone else stalls until its last beat.
            grant.found = valid_ext[owner_q];
            grant.idx   = owner_q;
        end

        sel_last = last_ext[grant.idx];
        // The chain carry replaces the requester carry on every locked beat.
        add_cin  = (state_q == ARB) ? carry_ext[grant.idx] : chain_c_q;

        for (int k = 0; k < N_REQ; k++) begin
            if (grant.idx == IDX_W'(k)) begin
                add_a          = i_data_one[k*WORD_W +: WORD_W];
                add_b          = i_data_two[k*WORD_W +: WORD_W];
                o_req_ready[k] = accept;
            end
        end
    end

    add_43bits u_add (
        .i_data_one (add_a),
        .i_data_two (add_b),
        .i_carry    (add_cin),
        .o_data     (add_sum),
        .o_carry    (add_cout)
    );

    // ---------------- Pointer, owner, chain carry, result slot ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            chain_c_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            // NOTE: the slot payload is reset too because its value is visible
            // on the outputs straight out of reset, not just when valid.
            slot_q      <= '0;
        end else begin
            if (accept) begin
                // Advancing on every beat is equivalent to advancing past the
                // owner at the end of a burst: the pointer is unused in LOCK.
                rr_ptr_q    <= rr_next(grant.idx, N_REQ);
                chain_c_q   <= add_cout;
                rsp_valid_q <= 1'b1;
                slot_q      <= '{data: add_sum, carry: add_cout, id: grant.idx, last: sel_last};
                if (state_q == ARB) begin
                    owner_q <= grant.idx;
                end
            end else if (i_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_data      = slot_q.data;
    assign o_carry     = slot_q.carry;
    assign o_rsp_id    = ID_W'(slot_q.id);
    assign o_rsp_last  = slot_q.last;

endmodule

// File: tb/tb_add_43bits_arb.sv
// ---------------------------------------------------------------------------
// tb_add_43bits_arb
//   Directed bench for add_43bits_arb with N_REQ=2. Inputs change 1 ns after
//   the rising edge; o_req_ready is sampled mid-cycle and registered outputs
//   1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_add_43bits_arb;

    localparam int N_REQ = 2;
    localparam int ID_W  = 2;
    localparam int W     = 43;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ*W-1:0]   data_one;
    logic [N_REQ*W-1:0]   data_two;
    logic [N_REQ-1:0]     carry_in;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_last;
    logic [W-1:0]         sum;
    logic                 carry_out;

    int n_vec = 0;
    int n_err = 0;

    add_43bits_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_last  (req_last),
        .i_data_one  (data_one),
        .i_data_two  (data_two),
        .i_carry     (carry_in),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_last  (rsp_last),
        .o_data      (sum),
        .o_carry     (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs (called just after a rising edge).
    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [1:0] c, input logic rr);
        req_valid = v;
        req_last  = l;
        data_one  = {a1, a0};
        data_two  = {b1, b0};
        carry_in  = c;
        rsp_ready = rr;
    endtask

    task automatic to_mid();
        #3;
    endtask

    task automatic to_next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b11, 2'b11, 43'd1, 43'd2, 43'd3, 43'd4, 2'b11, 1'b1);
        #12;
        n_vec++;
        if (req_ready !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        n_vec++;
        if ({rsp_valid, sum, carry_out, rsp_id, rsp_last} !== '0) begin
            n_err++; $display("FAIL reset_outputs: valid=%b data=%h c=%b id=%0d last=%b want all 0",
                              rsp_valid, sum, carry_out, rsp_id, rsp_last);
        end
        drive(2'b00, 2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        to_next_edge();
    endtask

    task automatic test_single_beat();
        drive(2'b01, 2'b01, 43'h1, 43'h7FF_FFFF_FFFF, '0, '0, 2'b00, 1'b1);
        to_mid();
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL single_ready: got %b want 01", req_ready);
        end
        to_next_edge();
        n_vec++;
        if ({rsp_valid, sum, carry_out, rsp_id, rsp_last} !== {1'b1, 43'h0, 1'b1, 2'd0, 1'b1}) begin
            n_err++; $display("FAIL single_result: valid=%b data=%h c=%b id=%0d last=%b want 1 0 1 0 1",
                              rsp_valid, sum, carry_out, rsp_id, rsp_last);
        end
        // Drain with nothing new: valid clears, data holds.
        drive(2'b00, 2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
        to_next_edge();
        n_vec++;
        if (rsp_valid !== 1'b0 || sum !== 43'h0 || carry_out !== 1'b1) begin
            n_err++; $display("FAIL single_drain: valid=%b data=%h c=%b want 0 0 1", rsp_valid, sum, carry_out);
        end
    endtask

    // Pointer sits at 1 after the single beat from requester 0.
    task automatic test_contention();
        logic [1:0]   exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [1:0]   exp_id  [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
        logic [W-1:0] exp_sum [4] = '{43'd200, 43'd101, 43'd202, 43'd103};
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b11, W'(i), 43'd100, W'(i), 43'd200, 2'b00, 1'b1);
            to_mid();
            n_vec++;
            if (req_ready !== exp_rdy[i]) begin
                n_err++; $display("FAIL contention_ready[%0d]: got %b want %b", i, req_ready, exp_rdy[i]);
            end
            to_next_edge();
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id[i] || sum !== exp_sum[i]) begin
                n_err++; $display("FAIL contention_rsp[%0d]: valid=%b id=%0d data=%0d want 1 %0d %0d",
                                  i, rsp_valid, rsp_id, sum, exp_id[i], exp_sum[i]);
            end
        end
    endtask

    // Pointer at 1: requester 1 wins and locks the adder for two beats.
    task automatic test_chain();
        drive(2'b11, 2'b01, 43'd9, 43'd9, ONES, 43'd1, 2'b00, 1'b1);
        to_mid();
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL chain_b0_ready: got %b want 10", req_ready);
        end
        to_next_edge();
        n_vec++;
        if ({sum, carry_out, rsp_id, rsp_last} !== {43'h0, 1'b1, 2'd1, 1'b0}) begin
            n_err++; $display("FAIL chain_b0: data=%h c=%b id=%0d last=%b want 0 1 1 0",
                              sum, carry_out, rsp_id, rsp_last);
        end
        drive(2'b11, 2'b11, 43'd9, 43'd9, 43'd0, 43'd0, 2'b00, 1'b1);
        to_mid();
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL chain_b1_ready: got %b want 10", req_ready);
        end
        to_next_edge();
        n_vec++;
        if ({sum, carry_out, rsp_id, rsp_last} !== {43'h1, 1'b0, 2'd1, 1'b1}) begin
            n_err++; $display("FAIL chain_b1: data=%h c=%b id=%0d last=%b want 1 0 1 1",
                              sum, carry_out, rsp_id, rsp_last);
        end
    endtask

    // Pointer at 0 after the chain.
    task automatic test_back_pressure();
        drive(2'b01, 2'b01, 43'h100, 43'h23, '0, '0, 2'b00, 1'b1);
        to_next_edge();
        n_vec++;
        if (rsp_valid !== 1'b1 || sum !== 43'h123) begin
            n_err++; $display("FAIL bp_load: valid=%b data=%h want 1 123", rsp_valid, sum);
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b11, 43'd5, 43'd5, 43'd7, 43'd8, 2'b00, 1'b0);
            to_mid();
            n_vec++;
            if (req_ready !== 2'b00) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b want 00", i, req_ready);
            end
            to_next_edge();
            n_vec++;
            if (rsp_valid !== 1'b1 || sum !== 43'h123 || rsp_id !== 2'd0) begin
                n_err++; $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%0d want 1 123 0", i, rsp_valid, sum, rsp_id);
            end
        end
        drive(2'b11, 2'b11, 43'd5, 43'd5, 43'd7, 43'd8, 2'b00, 1'b1);
        to_mid();
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL bp_release_ready: got %b want 10", req_ready);
        end
        to_next_edge();
        n_vec++;
        if (rsp_valid !== 1'b1 || sum !== 43'd15 || rsp_id !== 2'd1) begin
            n_err++; $display("FAIL bp_release: valid=%b data=%0d id=%0d want 1 15 1", rsp_valid, sum, rsp_id);
        end
    endtask

    // Pointer at 0: requester 1 alone starts a burst, then stalls.
    task automatic test_owner_stall();
        drive(2'b10, 2'b00, '0, '0, 43'd10, 43'd20, 2'b10, 1'b1);
        to_next_edge();
        n_vec++;
        if (sum !== 43'd31 || carry_out !== 1'b0 || rsp_id !== 2'd1) begin
            n_err++; $display("FAIL stall_b0: data=%0d c=%b id=%0d want 31 0 1", sum, carry_out, rsp_id);
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 2'b01, 43'd3, 43'd4, '0, '0, 2'b01, 1'b1);
            to_mid();
            n_vec++;
            if (req_ready !== 2'b00) begin
                n_err++; $display("FAIL stall_ready[%0d]: got %b want 00", i, req_ready);
            end
            to_next_edge();
        end
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_drained: valid=%b want 0", rsp_valid);
        end
        drive(2'b11, 2'b11, 43'd3, 43'd4, 43'd1, 43'd1, 2'b01, 1'b1);
        to_mid();
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL stall_last_ready: got %b want 10", req_ready);
        end
        to_next_edge();
        n_vec++;
        if (sum !== 43'd2 || rsp_last !== 1'b1 || rsp_id !== 2'd1) begin
            n_err++; $display("FAIL stall_last: data=%0d last=%b id=%0d want 2 1 1", sum, rsp_last, rsp_id);
        end
        drive(2'b11, 2'b11, 43'd3, 43'd4, 43'd1, 43'd1, 2'b01, 1'b1);
        to_mid();
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL stall_after_ready: got %b want 01", req_ready);
        end
        to_next_edge();
        n_vec++;
        if (sum !== 43'd8 || rsp_id !== 2'd0) begin
            n_err++; $display("FAIL stall_after: data=%0d id=%0d want 8 0", sum, rsp_id);
        end
    endtask

    // Pointer at 1: requester 1 starts a burst leaving chain carry = 1.
    task automatic test_reset_mid_burst();
        drive(2'b10, 2'b00, '0, '0, ONES, 43'd1, 2'b00, 1'b1);
        to_next_edge();
        n_vec++;
        if (sum !== 43'h0 || carry_out !== 1'b1 || rsp_last !== 1'b0) begin
            n_err++; $display("FAIL rmb_b0: data=%h c=%b last=%b want 0 1 0", sum, carry_out, rsp_last);
        end
        drive(2'b11, 2'b11, 43'd5, 43'd6, 43'd0, 43'd0, 2'b00, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid, sum, carry_out, rsp_id, rsp_last} !== '0 || req_ready !== 2'b00) begin
            n_err++; $display("FAIL rmb_async: valid=%b data=%h c=%b id=%0d last=%b rdy=%b want all 0",
                              rsp_valid, sum, carry_out, rsp_id, rsp_last, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        to_next_edge();
        drive(2'b01, 2'b01, 43'd5, 43'd6, '0, '0, 2'b00, 1'b1);
        to_mid();
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL rmb_ready: got %b want 01", req_ready);
        end
        to_next_edge();
        n_vec++;
        if ({rsp_valid, sum, carry_out, rsp_id} !== {1'b1, 43'd11, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL rmb_result: valid=%b data=%0d c=%b id=%0d want 1 11 0 0",
                              rsp_valid, sum, carry_out, rsp_id);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_contention();
        test_chain();
        test_back_pressure();
        test_owner_stall();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
